signal_generator_multi: RTL and testbench
=========================================

// Module: signal_generator_multi
// PURPOSE
//  Parametrised DDS waveform source feeding one DAC channel over AXI-Stream.
//  PHASE_WIDTH accumulator, modes off/sawtooth/triangle/square/trapezoid.
//  Amplitude scaling, DC offset and output saturation are built in.
//  Config is double-buffered and applied at phase wrap, so waveforms never glitch mid-period.
// PARAMETERS
//  AXIS_TDATA_WIDTH  16  output word width; DAC value sign-extended into it
//  DAC_WIDTH         14  signed sample width; FS = 2^(DAC_WIDTH-1)-1 = 8191
//  PHASE_WIDTH       32  phase accumulator width
//  SLOPE_WIDTH        8  trapezoid slope multiplier width
// PORTS
//  clk              in   1            clock
//  aresetn          in   1            reset, asynchronous, active-low
//  enable           in   1            run; 0 = hold/idle
//  cfg_update       in   1            strobe: capture cfg_* into shadow set
//  cfg_mode         in   3            0 off, 1 saw, 2 tri, 3 square, 4 trap; 5-7 = off
//  cfg_freq         in   PHASE_WIDTH  phase increment per output sample
//  cfg_phase_offset in   PHASE_WIDTH  phase loaded when enable rises
//  cfg_amplitude    in   DAC_WIDTH    unsigned gain; 2^(DAC_WIDTH-1) = unity, larger clamps to unity
//  cfg_offset       in   DAC_WIDTH    signed DC offset in LSB
//  cfg_slope        in   SLOPE_WIDTH  trapezoid steepness; 0 treated as 1
//  m_axis_tdata     out  AXIS_TDATA_WIDTH  sample
//  m_axis_tvalid    out  1            sample valid
//  m_axis_tready    in   1            downstream ready
//  m_axis_tuser     out  1            1 on first sample after phase wrap
//  cfg_pending      out  1            shadow set captured, not yet active
// BEHAVIOUR
//  Reset: all outputs 0, accumulator 0, active/shadow cfg 0 (mode off), pipeline valid bits 0.
//  Reset mid-run clears immediately; no partial sample is emitted after release.
//  Advance: adv = enable & (m_axis_tready | ~m_axis_tvalid). When adv=0, accumulator, pipeline and outputs all hold.
//  Accumulator: on each adv, acc <= acc + freq_active. wrap = carry out.
//  Enable 0->1: acc <= phase_offset_active, and the pipeline refills.
//  Shaping: u = acc[PHASE_WIDTH-1 -: DAC_WIDTH], unsigned 0..16383.
//   saw: u-8192, with -8192 clamped to -8191.
//   tri: u<8192 ? 2u-8191 : 8191-2(u-8192).
//   square: u<8192 ? +8191 : -8191.
//   trap: clamp(tri*slope, +/-8191).
//   off: 0.
//  Gain: (w * min(amp,8192)) >>> 13, arithmetic shift, full-width product.
//  Offset: y = clamp(gain + offset, -8191, +8191). -8192 is never output.
//  Pipeline: acc -> shape -> gain -> offset/sat -> output reg. Fixed latency of 4 adv cycles.
//   tvalid rises on the 4th adv after enable rises.
//  tuser travels down the pipeline with the sample whose phase came from the wrapping add.
//  enable=0: tvalid drops on the next clk, tdata holds its last value, and valid bits clear.
//  Config, idle (enable=0): cfg_update writes shadow and active directly; cfg_pending stays 0.
//  Config, running: cfg_update writes shadow, cfg_pending<=1. Active<=shadow on the next wrap; cfg_pending clears in that cycle.
//   The new cfg drives samples from that wrap onward; that sample carries tuser=1.
//  cfg_update coincident with wrap: the values sampled that cycle apply at that wrap, and cfg_pending stays 0.
//  Repeated cfg_update before wrap: the last one wins.
// TESTING
//  1 Async reset: assert aresetn=0 mid-run, between clk edges -> tdata=0, tvalid=0 immediately. Release with enable=0 -> both stay 0.
//  2 Saw: freq=2^18, amp=8192, offset=0, tready=1 -> first tvalid sample -8191 (tuser=1), then -8191, -8190, ... Period 16384 samples.
//  3 Tri and trap: freq=2^20, amp=8192.
//    tri -> -8191, -8183, ... +8191 at u=8192.
//    trap slope=4 -> +/-8191 flat wherever |tri|>=2048, 4x tri slope elsewhere.
//  4 Square, amp=8192, offset=+100 -> +8191 (saturated) and -8091. With amp=4096, offset=0 -> +4095 and -4096.
//  5 Deferred update: saw running, cfg_update mode=3 mid-period -> cfg_pending=1 and saw continues.
//    At wrap, cfg_pending=0; the first tuser=1 sample is +8191 square.
//  6 Backpressure: tready=0 for 5 cycles -> tdata/tvalid/tuser stable. After release the saw sequence continues with no sample lost or repeated.

Source files
------------

// File: rtl/signal_generator_multi.sv
// DDS waveform source: phase accumulator -> shaper -> gain -> offset/saturate -> AXI-Stream register.
// Configuration is double-buffered and swapped at phase wrap so no period is ever split.
module signal_generator_multi #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int DAC_WIDTH        = 14,
  parameter int PHASE_WIDTH      = 32,
  parameter int SLOPE_WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic                        cfg_update,
  input  logic [2:0]                  cfg_mode,
  input  logic [PHASE_WIDTH-1:0]      cfg_freq,
  input  logic [PHASE_WIDTH-1:0]      cfg_phase_offset,
  input  logic [DAC_WIDTH-1:0]        cfg_amplitude,
  input  logic [DAC_WIDTH-1:0]        cfg_offset,
  input  logic [SLOPE_WIDTH-1:0]      cfg_slope,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tuser,
  output logic                        cfg_pending
);

  localparam int DW   = DAC_WIDTH;
  localparam int PW   = PHASE_WIDTH;
  localparam int XW   = 2 * DAC_WIDTH + SLOPE_WIDTH + 2;
  localparam int FS   = 2 ** (DW - 1) - 1;
  localparam int HALF = 2 ** (DW - 1);

  typedef logic signed [XW-1:0] wide_t;
  typedef logic signed [DW-1:0] smp_t;

  typedef struct packed {
    logic [2:0]             mode;
    logic [PW-1:0]          freq;
    logic [PW-1:0]          phase;
    logic [DW-1:0]          amp;
    smp_t                   off;
    logic [SLOPE_WIDTH-1:0] slope;
  } cfg_t;

  localparam wide_t                  FS_X      = wide_t'(FS);
  localparam wide_t                  HALF_X    = wide_t'(HALF);
  localparam logic [DW-1:0]          AMP_MAX   = {1'b1, {(DW-1){1'b0}}};
  localparam logic [SLOPE_WIDTH-1:0] SLOPE_ONE = SLOPE_WIDTH'(1);

  function automatic smp_t sat(input wide_t x);
    if (x > FS_X)       return smp_t'(FS_X);
    else if (x < -FS_X) return smp_t'(-FS_X);
    else                return smp_t'(x);
  endfunction

  cfg_t cfg_in, act_q, act_d, shd_q, shd_d;
  logic pend_q, pend_d;
  logic en_q, adv, rise, wrap;
  logic [PW:0] sum;

  logic [PW-1:0] acc_q;
  logic          v0_q, u0_q;
  smp_t          w1_q, off1_q;
  logic [DW-1:0] amp1_q;
  logic          v1_q, u1_q;
  smp_t          g2_q, off2_q;
  logic          v2_q, u2_q;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q;
  logic          tvalid_q, tuser_q;

  logic [DW-1:0]          u, amp_c;
  logic [SLOPE_WIDTH-1:0] slope_c;
  wide_t                  uw, tri_x, sh_x, gp;
  smp_t                   w_d, g_d, y_d;

  assign cfg_in = '{cfg_mode, cfg_freq, cfg_phase_offset, cfg_amplitude, cfg_offset, cfg_slope};

  // Handshake: a sample transfers on a clk edge where tvalid & tready; while tvalid=1 and
  // tready=0 the whole pipeline stalls and tdata/tuser hold. Dropping enable withdraws tvalid.
  assign adv  = enable & (m_axis_tready | ~tvalid_q);
  assign rise = enable & ~en_q;
  assign sum  = {1'b0, acc_q} + {1'b0, act_q.freq};
  assign wrap = adv & ~rise & sum[PW];

  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    if (!enable) begin
      if (cfg_update) begin
        act_d  = cfg_in;
        shd_d  = cfg_in;
        pend_d = 1'b0;
      end
    end else if (wrap) begin
      pend_d = 1'b0;
      if (cfg_update) begin
        act_d = cfg_in;
        shd_d = cfg_in;
      end else if (pend_q) begin
        act_d = shd_q;
      end
    end else if (cfg_update) begin
      shd_d  = cfg_in;
      pend_d = 1'b1;
    end
  end

  // Shaping uses the active set; amp/offset travel with the sample so a swap never mixes sets.
  always_comb begin
    u       = acc_q[PW-1 -: DW];
    uw      = wide_t'(u);
    tri_x   = u[DW-1] ? (FS_X - ((uw - HALF_X) <<< 1)) : ((uw <<< 1) - FS_X);
    slope_c = (act_q.slope == '0) ? SLOPE_ONE : act_q.slope;
    amp_c   = (act_q.amp > AMP_MAX) ? AMP_MAX : act_q.amp;
    case (act_q.mode)
      3'd1:    sh_x = uw - HALF_X;
      3'd2:    sh_x = tri_x;
      3'd3:    sh_x = u[DW-1] ? -FS_X : FS_X;
      3'd4:    sh_x = tri_x * wide_t'(slope_c);
      default: sh_x = '0;
    endcase
    w_d = sat(sh_x);
    gp  = wide_t'(w1_q) * wide_t'(amp1_q);
    g_d = smp_t'(gp >>> (DW - 1));
    y_d = sat(wide_t'(g2_q) + wide_t'(off2_q));
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      en_q <= 1'b0; act_q <= '0; shd_q <= '0; pend_q <= 1'b0;
      acc_q <= '0; v0_q <= 1'b0; u0_q <= 1'b0;
      w1_q <= '0; off1_q <= '0; amp1_q <= '0; v1_q <= 1'b0; u1_q <= 1'b0;
      g2_q <= '0; off2_q <= '0; v2_q <= 1'b0; u2_q <= 1'b0;
      tdata_q <= '0; tvalid_q <= 1'b0; tuser_q <= 1'b0;
    end else begin
      en_q   <= enable;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      if (!enable) begin
        v0_q <= 1'b0; v1_q <= 1'b0; v2_q <= 1'b0; tvalid_q <= 1'b0;
        u0_q <= 1'b0; u1_q <= 1'b0; u2_q <= 1'b0; tuser_q  <= 1'b0;
      end else if (adv) begin
        acc_q    <= rise ? act_q.phase : sum[PW-1:0];
        u0_q     <= rise | sum[PW];
        v0_q     <= 1'b1;
        w1_q     <= w_d;
        amp1_q   <= amp_c;
        off1_q   <= act_q.off;
        u1_q     <= u0_q;
        v1_q     <= v0_q;
        g2_q     <= g_d;
        off2_q   <= off1_q;
        u2_q     <= u1_q;
        v2_q     <= v1_q;
        tdata_q  <= AXIS_TDATA_WIDTH'(y_d);
        tvalid_q <= v2_q;
        tuser_q  <= u2_q & v2_q;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tuser_q;
  assign cfg_pending   = pend_q;

endmodule

// File: tb/tb_signal_generator_multi.sv
// Scoreboard bench for signal_generator_multi: a reference model fills an expected queue per run
// and a negedge monitor pops and compares every accepted AXI-Stream sample.
module tb_signal_generator_multi;

  logic        clk = 1'b0;
  logic        aresetn, enable, cfg_update;
  logic [2:0]  cfg_mode;
  logic [31:0] cfg_freq, cfg_phase_offset;
  logic [13:0] cfg_amplitude, cfg_offset;
  logic [7:0]  cfg_slope;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tuser, cfg_pending;

  always #5 clk = ~clk;

  signal_generator_multi dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .cfg_update(cfg_update),
    .cfg_mode(cfg_mode), .cfg_freq(cfg_freq), .cfg_phase_offset(cfg_phase_offset),
    .cfg_amplitude(cfg_amplitude), .cfg_offset(cfg_offset), .cfg_slope(cfg_slope),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .cfg_pending(cfg_pending)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [16:0] exp_q[$];
  logic [16:0] hold_exp;

  int          md_mode, md_amp, md_off, md_slope, nx_mode, nx_amp, nx_off, nx_slope;
  logic [31:0] md_freq, md_phase, nx_freq, nx_phase;
  bit          md_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int clip(input int x);
    if (x > 8191) return 8191;
    if (x < -8191) return -8191;
    return x;
  endfunction

  function automatic int model_sample(input int mode, input int u, input int amp, input int off,
                                      input int slope);
    int s, t, a;
    t = (u < 8192) ? (2 * u - 8191) : (8191 - 2 * (u - 8192));
    case (mode)
      1: begin s = u - 8192; if (s == -8192) s = -8191; end
      2: s = t;
      3: s = (u < 8192) ? 8191 : -8191;
      4: s = clip(t * ((slope == 0) ? 1 : slope));
      default: s = 0;
    endcase
    a = (amp > 8192) ? 8192 : amp;
    return clip(((s * a) >>> 13) + off);
  endfunction

  // Pushes n expected {tuser,tdata}; also predicts the sample left on the bus after the run.
  task automatic push_run(input int n);
    logic [31:0] ph;
    logic [32:0] s;
    logic [16:0] e;
    bit          wr;
    int          y;
    ph = md_phase;
    wr = 1'b1;
    for (int k = 0; k <= n; k++) begin
      if (k > 0 && wr && md_pend) begin
        md_mode = nx_mode; md_freq = nx_freq; md_phase = nx_phase;
        md_amp  = nx_amp;  md_off  = nx_off;  md_slope = nx_slope;
        md_pend = 1'b0;
      end
      y = model_sample(md_mode, int'(ph[31:18]), md_amp, md_off, md_slope);
      e = {wr, 16'(y)};
      if (k < n) exp_q.push_back(e);
      else hold_exp = e;
      s  = {1'b0, ph} + {1'b0, md_freq};
      wr = s[32];
      ph = s[31:0];
    end
  endtask

  task automatic drive_cfg(input int mode, input logic [31:0] freq, input logic [31:0] phase,
                           input int amp, input int off, input int slope);
    @(posedge clk); #1;
    cfg_mode = 3'(mode); cfg_freq = freq; cfg_phase_offset = phase;
    cfg_amplitude = 14'(amp); cfg_offset = 14'(off); cfg_slope = 8'(slope);
    cfg_update = 1'b1;
    @(posedge clk); #1;
    cfg_update = 1'b0;
  endtask

  task automatic cfg_idle(input int mode, input logic [31:0] freq, input logic [31:0] phase,
                          input int amp, input int off, input int slope);
    drive_cfg(mode, freq, phase, amp, off, slope);
    md_mode = mode; md_freq = freq; md_phase = phase;
    md_amp = amp; md_off = off; md_slope = slope;
    check("idle_pending", 32'(cfg_pending), 32'd0);
  endtask

  task automatic start_run();
    @(posedge clk); #1;
    enable = 1'b1; m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("lat_before4", 32'(m_axis_tvalid), 32'd0);
    @(posedge clk);
    #1 check("lat_at4", 32'(m_axis_tvalid), 32'd1);
  endtask

  task automatic drain_stop(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    #1;
    enable = 1'b0; m_axis_tready = 1'b0;
    @(posedge clk); #1;
    check("stop_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("stop_hold", 32'(m_axis_tdata), 32'(hold_exp[15:0]));
  endtask

  task automatic stall(input int cycles);
    m_axis_tready = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(m_axis_tvalid), 32'd1);
      check("stall_sample", 32'({m_axis_tuser, m_axis_tdata}), 32'(exp_q[0]));
    end
    m_axis_tready = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [17:0] e;
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() > 0) e = {1'b1, exp_q.pop_front()};
      else e = '0;
      check("sample", 32'({1'b1, m_axis_tuser, m_axis_tdata}), 32'(e));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; enable = 1'b0; cfg_update = 1'b0; m_axis_tready = 1'b0;
    cfg_mode = '0; cfg_freq = '0; cfg_phase_offset = '0;
    cfg_amplitude = '0; cfg_offset = '0; cfg_slope = '0;
    md_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tuser", 32'(m_axis_tuser), 32'd0);
    check("rst_pending", 32'(cfg_pending), 32'd0);
    @(posedge clk); #1 aresetn = 1'b1;

    // Reset in the middle of a run, between clock edges
    cfg_idle(1, 32'h0004_0000, 32'h0, 8192, 0, 0);
    push_run(200);
    start_run();
    repeat (10) @(posedge clk);
    #3;
    aresetn = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_tdata", 32'(m_axis_tdata), 32'd0);
    check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    enable = 1'b0; m_axis_tready = 1'b0;
    @(posedge clk); #1 aresetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rel_tdata", 32'(m_axis_tdata), 32'd0);
    check("rel_tvalid", 32'(m_axis_tvalid), 32'd0);
    md_pend = 1'b0;

    // Saw over a full period plus wrap, with a 5-cycle backpressure window
    cfg_idle(1, 32'h0004_0000, 32'h0, 8192, 0, 0);
    push_run(16390);
    start_run();
    repeat (20) @(posedge clk);
    #1 stall(5);
    drain_stop(16500);

    // Triangle, trapezoid (slope 4 and slope 0)
    cfg_idle(2, 32'h0010_0000, 32'h0, 8192, 0, 0);
    push_run(4100); start_run(); drain_stop(4200);
    cfg_idle(4, 32'h0010_0000, 32'h0, 8192, 0, 4);
    push_run(4100); start_run(); drain_stop(4200);
    cfg_idle(4, 32'h0100_0000, 32'h0, 8192, 0, 0);
    push_run(260); start_run(); drain_stop(400);

    // Square with offset saturation and half gain; clamped gain, phase offset, negative offset
    cfg_idle(3, 32'h0100_0000, 32'h0, 8192, 100, 0);
    push_run(300); start_run(); drain_stop(400);
    cfg_idle(3, 32'h0100_0000, 32'h0, 4096, 0, 0);
    push_run(300); start_run(); drain_stop(400);
    cfg_idle(1, 32'h0040_0000, 32'h4000_0000, 12000, -200, 0);
    push_run(300); start_run(); drain_stop(400);
    cfg_idle(7, 32'h0100_0000, 32'h0, 8192, 0, 0);
    push_run(20); start_run(); drain_stop(100);

    // Deferred update while running: two updates before the wrap, the last one wins
    cfg_idle(1, 32'h0100_0000, 32'h0, 8192, 0, 0);
    nx_mode = 3; nx_freq = 32'h0100_0000; nx_phase = 32'h0;
    nx_amp = 8192; nx_off = 0; nx_slope = 0;
    md_pend = 1'b1;
    push_run(300);
    start_run();
    repeat (36) @(posedge clk);
    drive_cfg(2, 32'h0080_0000, 32'h1234_0000, 5000, 7, 3);
    check("run_pending1", 32'(cfg_pending), 32'd1);
    drive_cfg(3, 32'h0100_0000, 32'h0, 8192, 0, 0);
    check("run_pending2", 32'(cfg_pending), 32'd1);
    drain_stop(400);
    check("wrap_pending", 32'(cfg_pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
